decode_format_queue: RTL and testbench



---
 rtl/decode_pkg.sv | 81 ++++++++
 rtl/format_classifier.sv | 15 +
 rtl/decode_format_queue.sv | 103 ++++++++++
 tb/tb_decode_format_queue.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: format bits, primary opcodes, opcode classification and the
// queue entry layout used by the format-decode front end.
package decode_pkg;

   localparam int unsigned AddrWidth   = 64;
   localparam int unsigned InstrWidth  = 32;
   localparam int unsigned PidWidth    = 20;
   localparam int unsigned TidWidth    = 16;
   localparam int unsigned MajIdWidth  = 64;
   localparam int unsigned OpcodeSize  = 6;
   localparam int unsigned FormatWidth = 23;

   localparam logic [FormatWidth-1:0] FmtI   = 23'h000001;
   localparam logic [FormatWidth-1:0] FmtB   = 23'h000002;
   localparam logic [FormatWidth-1:0] FmtXl  = 23'h000004;
   localparam logic [FormatWidth-1:0] FmtDx  = 23'h000008;
   localparam logic [FormatWidth-1:0] FmtSc  = 23'h000010;
   localparam logic [FormatWidth-1:0] FmtD   = 23'h000020;
   localparam logic [FormatWidth-1:0] FmtDs  = 23'h001000;
   localparam logic [FormatWidth-1:0] FmtDq  = 23'h002000;
   localparam logic [FormatWidth-1:0] FmtXx2 = 23'h200000;
   localparam logic [FormatWidth-1:0] FmtXx3 = 23'h400000;

   // Multi-format class masks for the opcodes that decode to more than one format.
   localparam logic [FormatWidth-1:0] MaskExt = 23'd3776;
   localparam logic [FormatWidth-1:0] MaskRld = 23'd393216;
   localparam logic [FormatWidth-1:0] MaskVmx = 23'd114688;
   localparam logic [FormatWidth-1:0] MaskFps = 23'd1049408;
   localparam logic [FormatWidth-1:0] MaskFp  = 23'd1575744;

   localparam logic [OpcodeSize-1:0] OpVmx   = 6'd4;
   localparam logic [OpcodeSize-1:0] OpAddi  = 6'd14;
   localparam logic [OpcodeSize-1:0] OpAddis = 6'd15;
   localparam logic [OpcodeSize-1:0] OpBc    = 6'd16;
   localparam logic [OpcodeSize-1:0] OpSc    = 6'd17;
   localparam logic [OpcodeSize-1:0] OpB     = 6'd18;
   localparam logic [OpcodeSize-1:0] OpCr    = 6'd19;
   localparam logic [OpcodeSize-1:0] OpRld   = 6'd30;
   localparam logic [OpcodeSize-1:0] OpExt   = 6'd31;
   localparam logic [OpcodeSize-1:0] OpLwz   = 6'd32;
   localparam logic [OpcodeSize-1:0] OpStfdu = 6'd55;
   localparam logic [OpcodeSize-1:0] OpLq    = 6'd56;
   localparam logic [OpcodeSize-1:0] OpLd    = 6'd58;
   localparam logic [OpcodeSize-1:0] OpFps   = 6'd59;
   localparam logic [OpcodeSize-1:0] OpVsx   = 6'd60;
   localparam logic [OpcodeSize-1:0] OpStd   = 6'd62;
   localparam logic [OpcodeSize-1:0] OpFp    = 6'd63;

   typedef struct packed {
      logic [InstrWidth-1:0]  instruction;
      logic [AddrWidth-1:0]   address;
      logic [PidWidth-1:0]    pid;
      logic [TidWidth-1:0]    tid;
      logic [MajIdWidth-1:0]  maj_id;
      logic [FormatWidth-1:0] format;
      logic                   illegal;
   } entry_t;

   function automatic logic [FormatWidth-1:0] opcode_to_format(input logic [OpcodeSize-1:0] op);
      logic [FormatWidth-1:0] mask;
      mask = '0;
      case (op) inside
         OpB:                             mask = FmtI;
         OpBc:                            mask = FmtB;
         OpCr:                            mask = FmtXl | FmtDx;
         OpSc:                            mask = FmtSc;
         OpAddi, OpAddis, [OpLwz:OpStfdu]: mask = FmtD;
         OpExt:                           mask = MaskExt;
         OpRld:                           mask = MaskRld;
         OpLd, OpStd:                     mask = FmtDs;
         OpLq:                            mask = FmtDq;
         OpVmx:                           mask = MaskVmx;
         OpFps:                           mask = MaskFps;
         OpFp:                            mask = MaskFp;
         OpVsx:                           mask = FmtXx2 | FmtXx3;
         default:                         mask = '0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/format_classifier.sv
// Combinational primary-opcode to format-mask table; an opcode matching no format is illegal.
module format_classifier
   import decode_pkg::*;
(
   input  logic [OpcodeSize-1:0]  opcode_i,
   output logic [FormatWidth-1:0] format_o,
   output logic                   illegal_o
);

   always_comb begin
      format_o  = opcode_to_format(opcode_i);
      illegal_o = ~|format_o;
   end

endmodule

// File: rtl/decode_format_queue.sv
// In-order instruction queue between fetch and the format decoders; entries are classified on
// enqueue and presented first-word fall-through under a valid/ready/stall handshake.
module decode_format_queue
   import decode_pkg::*;
#(
   parameter int unsigned addressWidth            = AddrWidth,
   parameter int unsigned instructionWidth        = InstrWidth,
   parameter int unsigned PidSize                 = PidWidth,
   parameter int unsigned TidSize                 = TidWidth,
   parameter int unsigned instructionCounterWidth = MajIdWidth,
   parameter int unsigned opcodeSize              = OpcodeSize,
   parameter int unsigned formatWidth             = FormatWidth,
   parameter int unsigned queueDepth              = 4
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               enable_i,
   input  logic                               flush_i,
   input  logic                               stall_i,
   input  logic                               valid_i,
   output logic                               ready_o,
   input  logic [instructionWidth-1:0]        instruction_i,
   input  logic [addressWidth-1:0]            instructionAddress_i,
   input  logic [PidSize-1:0]                 instructionPid_i,
   input  logic [TidSize-1:0]                 instructionTid_i,
   input  logic [instructionCounterWidth-1:0] instructionMajId_i,
   output logic                               valid_o,
   output logic [formatWidth-1:0]             instFormat_o,
   output logic                               illegal_o,
   output logic [instructionWidth-1:0]        instruction_o,
   output logic [addressWidth-1:0]            instructionAddress_o,
   output logic [PidSize-1:0]                 instructionPid_o,
   output logic [TidSize-1:0]                 instructionTid_o,
   output logic [instructionCounterWidth-1:0] instructionMajId_o,
   output logic [$clog2(queueDepth):0]        count_o
);

   localparam int unsigned PtrW = $clog2(queueDepth);
   localparam int unsigned CntW = PtrW + 1;

   entry_t                 mem_q [queueDepth];
   logic   [PtrW-1:0]      wptr_q, rptr_q;
   logic   [CntW-1:0]      count_q;
   logic   [FormatWidth-1:0] in_format;
   logic                   in_illegal;
   entry_t                 in_entry, head;
   logic                   push, pop;

   // Opcode sits in the most-significant bits (big-endian bit numbering 0..5).
   format_classifier u_classifier (
      .opcode_i  (instruction_i[instructionWidth-1 -: opcodeSize]),
      .format_o  (in_format),
      .illegal_o (in_illegal)
   );

   assign ready_o = (count_q < CntW'(queueDepth));
   assign valid_o = (count_q != '0);
   assign push    = enable_i & valid_i & ready_o & ~flush_i;
   assign pop     = enable_i & valid_o & ~stall_i & ~flush_i;

   always_comb begin
      in_entry             = '0;
      in_entry.instruction = instruction_i;
      in_entry.address     = instructionAddress_i;
      in_entry.pid         = instructionPid_i;
      in_entry.tid         = instructionTid_i;
      in_entry.maj_id      = instructionMajId_i;
      in_entry.format      = in_format;
      in_entry.illegal     = in_illegal;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < int'(queueDepth); i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= in_entry;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   assign head                 = mem_q[rptr_q];
   assign instFormat_o         = head.format;
   assign illegal_o            = head.illegal;
   assign instruction_o        = head.instruction;
   assign instructionAddress_o = head.address;
   assign instructionPid_o     = head.pid;
   assign instructionTid_o     = head.tid;
   assign instructionMajId_o   = head.maj_id;
   assign count_o              = count_q;

endmodule

// File: tb/tb_decode_format_queue.sv
// Self-checking bench for decode_format_queue: classification table, directed handshake
// sequences and a randomized run against a queue-based reference model.
module tb_decode_format_queue;

   logic        clock, reset, enable, flush, stall, valid_in;
   logic        ready, valid_out, illegal;
   logic [31:0] instr_in, instr_out;
   logic [63:0] addr_in, addr_out, maj_in, maj_out;
   logic [19:0] pid_in, pid_out;
   logic [15:0] tid_in, tid_out;
   logic [22:0] fmt_out;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [5:0] op;
      int         mask;
      bit         ill;
   } vec_t;

   typedef struct {
      logic [31:0] ins;
      logic [63:0] addr;
      logic [19:0] pid;
      logic [15:0] tid;
      logic [63:0] maj;
   } ent_t;

   vec_t vecs[$];
   ent_t model[$];

   decode_format_queue dut (
      .clock_i              (clock),
      .reset_i              (reset),
      .enable_i             (enable),
      .flush_i              (flush),
      .stall_i              (stall),
      .valid_i              (valid_in),
      .ready_o              (ready),
      .instruction_i        (instr_in),
      .instructionAddress_i (addr_in),
      .instructionPid_i     (pid_in),
      .instructionTid_i     (tid_in),
      .instructionMajId_i   (maj_in),
      .valid_o              (valid_out),
      .instFormat_o         (fmt_out),
      .illegal_o            (illegal),
      .instruction_o        (instr_out),
      .instructionAddress_o (addr_out),
      .instructionPid_o     (pid_out),
      .instructionTid_o     (tid_out),
      .instructionMajId_o   (maj_out),
      .count_o              (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Spec classification rules, used by the randomized run.
   function automatic int exp_mask(input logic [5:0] op);
      int o;
      o = int'(op);
      if (o == 18) return 1;
      if (o == 16) return 2;
      if (o == 19) return 12;
      if (o == 17) return 16;
      if (o == 14 || o == 15 || (o >= 32 && o <= 55)) return 32;
      if (o == 31) return 3776;
      if (o == 30) return 393216;
      if (o == 58 || o == 62) return 4096;
      if (o == 56) return 8192;
      if (o == 4) return 114688;
      if (o == 59) return 1049408;
      if (o == 63) return 1575744;
      if (o == 60) return 6291456;
      return 0;
   endfunction

   task automatic drive(input bit v, input logic [5:0] op, input logic [63:0] maj);
      valid_in = v;
      instr_in = {op, 26'($urandom)};
      addr_in  = {$urandom, $urandom};
      pid_in   = 20'($urandom);
      tid_in   = 16'($urandom);
      maj_in   = maj;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [5:0] exp_ops [4];
      int         exp_masks [4];
      logic [5:0] ops_list [14];

      reset = 1'b1; enable = 1'b1; flush = 1'b0; stall = 1'b0;
      drive(1'b0, 6'd0, 64'd0);
      step();
      do_reset();

      // Reset state
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_fmt", 64'(fmt_out), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_instr", 64'(instr_out), 64'd0);
      chk("rst_addr", addr_out, 64'd0);
      chk("rst_maj", maj_out, 64'd0);

      // Single opcode-18 push
      valid_in = 1'b1; instr_in = 32'h4800_0010; addr_in = 64'h1000;
      pid_in = 20'h12345; tid_in = 16'hbeef; maj_in = 64'd7;
      chk("one_no_bypass", 64'(valid_out), 64'd0);
      step();
      valid_in = 1'b0;
      chk("one_valid", 64'(valid_out), 64'd1);
      chk("one_fmt", 64'(fmt_out), 64'd1);
      chk("one_illegal", 64'(illegal), 64'd0);
      chk("one_addr", addr_out, 64'h1000);
      chk("one_pid", 64'(pid_out), 64'h12345);
      chk("one_tid", 64'(tid_out), 64'hbeef);
      chk("one_count", 64'(count), 64'd1);
      step();
      chk("one_drained", 64'(count), 64'd0);

      // Classification table
      vecs.push_back('{6'd18, 1, 1'b0});
      vecs.push_back('{6'd16, 2, 1'b0});
      vecs.push_back('{6'd19, 12, 1'b0});
      vecs.push_back('{6'd17, 16, 1'b0});
      vecs.push_back('{6'd14, 32, 1'b0});
      vecs.push_back('{6'd15, 32, 1'b0});
      vecs.push_back('{6'd32, 32, 1'b0});
      vecs.push_back('{6'd55, 32, 1'b0});
      vecs.push_back('{6'd31, 3776, 1'b0});
      vecs.push_back('{6'd30, 393216, 1'b0});
      vecs.push_back('{6'd58, 4096, 1'b0});
      vecs.push_back('{6'd62, 4096, 1'b0});
      vecs.push_back('{6'd56, 8192, 1'b0});
      vecs.push_back('{6'd4, 114688, 1'b0});
      vecs.push_back('{6'd59, 1049408, 1'b0});
      vecs.push_back('{6'd63, 1575744, 1'b0});
      vecs.push_back('{6'd60, 6291456, 1'b0});
      vecs.push_back('{6'd0, 0, 1'b1});
      vecs.push_back('{6'd13, 0, 1'b1});
      vecs.push_back('{6'd57, 0, 1'b1});
      vecs.push_back('{6'd61, 0, 1'b1});
      vecs.push_back('{6'd29, 0, 1'b1});
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].op, 64'(i));
         step();
         valid_in = 1'b0;
         chk($sformatf("tbl_fmt_op%0d", vecs[i].op), 64'(fmt_out), 64'(vecs[i].mask));
         chk($sformatf("tbl_ill_op%0d", vecs[i].op), 64'(illegal), 64'(vecs[i].ill));
         step();
      end

      // Fill to full under stall; 5th push ignored; drain in order
      exp_ops = '{6'd14, 6'd31, 6'd63, 6'd0};
      exp_masks = '{32, 3776, 1575744, 0};
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, exp_ops[k], 64'(200 + k));
         step();
      end
      chk("full_ready", 64'(ready), 64'd0);
      chk("full_count", 64'(count), 64'd4);
      drive(1'b1, 6'd18, 64'd999);
      step();
      chk("full_5th_count", 64'(count), 64'd4);
      chk("full_5th_head", maj_out, 64'd200);
      valid_in = 1'b0; stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain_count%0d", k), 64'(count), 64'(4 - k));
         chk($sformatf("drain_fmt%0d", k), 64'(fmt_out), 64'(exp_masks[k]));
         chk($sformatf("drain_ill%0d", k), 64'(illegal), 64'(k == 3));
         chk($sformatf("drain_maj%0d", k), maj_out, 64'(200 + k));
         step();
      end
      chk("drain_empty", 64'(count), 64'd0);
      chk("drain_valid", 64'(valid_out), 64'd0);

      // Continuous push and pop, pointers wrap
      drive(1'b1, 6'd31, 64'd100);
      step();
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 6'd14, 64'(100 + k));
         chk($sformatf("stream_count%0d", k), 64'(count), 64'd1);
         chk($sformatf("stream_maj%0d", k), maj_out, 64'(100 + k - 1));
         step();
      end
      valid_in = 1'b0;
      chk("stream_last", maj_out, 64'd110);
      step();
      chk("stream_empty", 64'(count), 64'd0);

      // Flush with a concurrent push
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 6'd18, 64'(300 + k));
         step();
      end
      drive(1'b1, 6'd18, 64'd333);
      flush = 1'b1;
      step();
      flush = 1'b0; valid_in = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(valid_out), 64'd0);
      step();
      chk("flush_dropped", 64'(valid_out), 64'd0);
      stall = 1'b0;
      drive(1'b1, 6'd16, 64'd400);
      step();
      valid_in = 1'b0;
      chk("flush_new_head", maj_out, 64'd400);
      chk("flush_new_fmt", 64'(fmt_out), 64'd2);
      step();

      // Enable low holds everything
      stall = 1'b1;
      drive(1'b1, 6'd18, 64'd500); step();
      drive(1'b1, 6'd16, 64'd501); step();
      stall = 1'b0; enable = 1'b0;
      drive(1'b1, 6'd19, 64'd502);
      for (int k = 0; k < 3; k++) step();
      chk("dis_count", 64'(count), 64'd2);
      chk("dis_head", maj_out, 64'd500);
      chk("dis_valid", 64'(valid_out), 64'd1);
      enable = 1'b1; valid_in = 1'b0;
      step();
      chk("en_count", 64'(count), 64'd1);
      chk("en_head", maj_out, 64'd501);
      enable = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0; enable = 1'b1;
      chk("dis_flush_count", 64'(count), 64'd0);

      // Reset while full and stalled
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 6'd63, 64'(600 + k));
         step();
      end
      valid_in = 1'b0;
      chk("pre_rst_count", 64'(count), 64'd4);
      do_reset();
      stall = 1'b0;
      chk("mid_rst_ready", 64'(ready), 64'd1);
      chk("mid_rst_valid", 64'(valid_out), 64'd0);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_instr", 64'(instr_out), 64'd0);
      chk("mid_rst_addr", addr_out, 64'd0);
      chk("mid_rst_pid", 64'(pid_out), 64'd0);
      chk("mid_rst_tid", 64'(tid_out), 64'd0);
      chk("mid_rst_maj", maj_out, 64'd0);
      chk("mid_rst_fmt", 64'(fmt_out), 64'd0);
      chk("mid_rst_ill", 64'(illegal), 64'd0);

      // Randomized run against the reference queue
      ops_list = '{6'd4, 6'd14, 6'd16, 6'd17, 6'd18, 6'd19, 6'd30, 6'd31, 6'd40,
                   6'd56, 6'd58, 6'd59, 6'd60, 6'd63};
      model.delete();
      for (int c = 0; c < 600; c++) begin
         bit         en, fl, st, vl, rs, push, pop;
         logic [5:0] op;
         ent_t       e;
         en = ($urandom_range(0, 9) != 0);
         fl = ($urandom_range(0, 39) == 0);
         rs = ($urandom_range(0, 99) == 0);
         st = ($urandom_range(0, 2) == 0);
         vl = ($urandom_range(0, 3) != 0);
         op = ($urandom_range(0, 3) != 0) ? ops_list[$urandom_range(0, 13)] : 6'($urandom);

         chk("rnd_count", 64'(count), 64'(model.size()));
         chk("rnd_ready", 64'(ready), 64'(model.size() < 4));
         chk("rnd_valid", 64'(valid_out), 64'(model.size() != 0));
         if (model.size() != 0) begin
            chk("rnd_instr", 64'(instr_out), 64'(model[0].ins));
            chk("rnd_addr", addr_out, model[0].addr);
            chk("rnd_pid", 64'(pid_out), 64'(model[0].pid));
            chk("rnd_tid", 64'(tid_out), 64'(model[0].tid));
            chk("rnd_maj", maj_out, model[0].maj);
            chk("rnd_fmt", 64'(fmt_out), 64'(exp_mask(model[0].ins[31:26])));
            chk("rnd_ill", 64'(illegal), 64'(exp_mask(model[0].ins[31:26]) == 0));
         end

         enable = en; flush = fl; stall = st; reset = rs;
         drive(vl, op, {$urandom, $urandom});
         e.ins = instr_in; e.addr = addr_in; e.pid = pid_in; e.tid = tid_in; e.maj = maj_in;
         push = en && vl && (model.size() < 4) && !fl;
         pop  = en && (model.size() != 0) && !st && !fl;
         if (rs || fl) begin
            model.delete();
         end else begin
            if (pop) void'(model.pop_front());
            if (push) model.push_back(e);
         end
         step();
      end
      reset = 1'b0; flush = 1'b0; valid_in = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
